// File: rtl/mips_wb_pkg.sv
// mips_wb_pkg: shared widths, forwarding codes and the late-write FIFO entry.
package mips_wb_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam logic [1:0] FWD_PORT1 = 2'b01;
  localparam logic [1:0] FWD_PORT2 = 2'b10;
  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] wreg;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;
endpackage

// File: rtl/wb_late_fifo.sv
// wb_late_fifo: pending late-result queue with per-entry squash by destination register.
module wb_late_fifo
  import mips_wb_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int PTR_W = DEPTH > 1 ? $clog2(DEPTH) : 1,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  push,
  input  logic [REG_ADDR_W-1:0] push_reg,
  input  logic [DATA_W-1:0]     push_data,
  input  logic                  pop,
  input  logic                  squash,
  input  logic [REG_ADDR_W-1:0] squash_reg,
  output wb_entry_t             head,
  output logic [CNT_W-1:0]      count
);
  wb_entry_t mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
    return p == PTR_W'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign head = mem[rd_ptr];
  always_ff @(posedge Clk)
    if (Reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (squash && mem[i].wreg == squash_reg) mem[i].valid <= 1'b0;
      if (push) begin
        mem[wr_ptr] <= '{valid: 1'b1, wreg: push_reg, data: push_data};
        wr_ptr      <= nxt(wr_ptr);
      end
      if (pop) rd_ptr <= nxt(rd_ptr);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
endmodule

// File: rtl/wb_write_port_arbiter.sv
// wb_write_port_arbiter: MEM/WB register merging pipeline writes with queued late results.
// Define WB_WRITE_STATS_EN to add per-source write counters.
module wb_write_port_arbiter
  import mips_wb_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int PTR_W = DEPTH > 1 ? $clog2(DEPTH) : 1,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  RegWrite_MEM,
  input  logic                  MemtoReg_MEM,
  input  logic [REG_ADDR_W-1:0] Write_Register_MEM,
  input  logic [DATA_W-1:0]     ALU_Result_MEM,
  input  logic [DATA_W-1:0]     Read_Data_MEM,
  input  logic                  Late_Valid,
  input  logic [REG_ADDR_W-1:0] Late_Register,
  input  logic [DATA_W-1:0]     Late_Data,
  output logic                  Late_Ready,
  input  logic [REG_ADDR_W-1:0] Read_Address_1_ID,
  input  logic [REG_ADDR_W-1:0] Read_Address_2_ID,
  output logic [REG_ADDR_W-1:0] Write_Register_WB,
  output logic [DATA_W-1:0]     Write_Data_WB,
  output logic                  RegWrite_WB,
  output logic [1:0]            Forward_Reg_Delay
`ifdef WB_WRITE_STATS_EN
  ,
  output logic [31:0]           Pipe_Write_Count,
  output logic [31:0]           Late_Write_Count
`endif
);
  logic pipe_wr, pop, accept, bypass, push, late_wr, fwd_ok;
  wb_entry_t head;
  logic [CNT_W-1:0] count;
  assign pipe_wr    = RegWrite_MEM && Write_Register_MEM != '0;
  assign pop        = !pipe_wr && count != '0;
  assign Late_Ready = !Reset && (count < CNT_W'(DEPTH) || pop);
  assign accept     = Late_Valid && Late_Ready;
  assign bypass     = accept && !pipe_wr && count == '0 && Late_Register != '0;
  // results for $0 or for the register the pipeline is writing right now are dropped
  assign push       = accept && Late_Register != '0 &&
                      (pipe_wr ? Late_Register != Write_Register_MEM : count != '0);
  assign late_wr    = (pop && head.valid) || bypass;
  wb_late_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W), .CNT_W(CNT_W)) u_fifo (
    .Clk        (Clk),
    .Reset      (Reset),
    .push       (push),
    .push_reg   (Late_Register),
    .push_data  (Late_Data),
    .pop        (pop),
    .squash     (pipe_wr),
    .squash_reg (Write_Register_MEM),
    .head       (head),
    .count      (count)
  );
  always_ff @(posedge Clk)
    if (Reset) begin
      RegWrite_WB       <= 1'b0;
      Write_Register_WB <= '0;
      Write_Data_WB     <= '0;
    end else begin
      RegWrite_WB <= pipe_wr || late_wr;
      if (pipe_wr) begin
        Write_Register_WB <= Write_Register_MEM;
        Write_Data_WB     <= MemtoReg_MEM ? Read_Data_MEM : ALU_Result_MEM;
      end else if (pop && head.valid) begin
        Write_Register_WB <= head.wreg;
        Write_Data_WB     <= head.data;
      end else if (bypass) begin
        Write_Register_WB <= Late_Register;
        Write_Data_WB     <= Late_Data;
      end
    end
  assign fwd_ok            = RegWrite_WB && Write_Register_WB != '0;
  assign Forward_Reg_Delay = (fwd_ok && Write_Register_WB == Read_Address_1_ID ? FWD_PORT1 : 2'b00) |
                             (fwd_ok && Write_Register_WB == Read_Address_2_ID ? FWD_PORT2 : 2'b00);
`ifdef WB_WRITE_STATS_EN
  always_ff @(posedge Clk)
    if (Reset) begin
      Pipe_Write_Count <= '0;
      Late_Write_Count <= '0;
    end else begin
      Pipe_Write_Count <= Pipe_Write_Count + 32'(pipe_wr);
      Late_Write_Count <= Late_Write_Count + 32'(late_wr);
    end
`endif
endmodule
